// File: rtl/ctrl_ascensor.sv
// ctrl_ascensor: elevator motion controller driving an external 4-bit up-counter
// used as the floor register. It steps the cabin one floor at a time, reads the
// floor back on Q, and runs a door-open interval at the target floor.
module ctrl_ascensor #(
  parameter int NUM_FLOORS  = 16,
  parameter int STEP_CYCLES = 4,
  parameter int DOOR_CYCLES = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [3:0] req_floor,
  output logic       req_ready,
  output logic       req_err,
  input  logic       stop,
  input  logic [3:0] Q,
  output logic       enb,
  output logic       modo,
  output logic [3:0] data,
  output logic       door_open,
  output logic       moving_up,
  output logic       moving_down
);

  localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [SW-1:0] STEP_LOAD = SW'(STEP_CYCLES - 1);
  localparam logic [DW-1:0] DOOR_LOAD = DW'(DOOR_CYCLES - 1);
  localparam logic [4:0]    FLOOR_LIM = 5'(NUM_FLOORS);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_MOVE_UP,
    ST_SETTLE_UP,
    ST_MOVE_DOWN,
    ST_SETTLE_DOWN,
    ST_DOOR
  } state_t;

  state_t        state, state_nx;
  logic [3:0]    target, target_nx;
  logic [SW-1:0] step_tmr, step_nx;
  logic [DW-1:0] door_tmr, door_nx;
  logic          err_q, err_nx;

  logic          enb_c, modo_c, ready_c, door_c, up_c, dn_c;
  logic [3:0]    data_c;
  logic          floor_bad;

  assign floor_bad = ({1'b0, req_floor} >= FLOOR_LIM);

  // State, target, timers and the error pulse flag; all cleared by reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_INIT;
      target   <= '0;
      step_tmr <= '0;
      door_tmr <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nx;
      target   <= target_nx;
      step_tmr <= step_nx;
      door_tmr <= door_nx;
      err_q    <= err_nx;
    end
  end

  // Next-state and Moore-style outputs; step pulse issued when the timer hits 0
  always_comb begin
    state_nx  = state;
    target_nx = target;
    step_nx   = step_tmr;
    door_nx   = door_tmr;
    err_nx    = 1'b0;
    enb_c     = 1'b0;
    modo_c    = 1'b0;
    data_c    = 4'd0;
    ready_c   = 1'b0;
    door_c    = 1'b0;
    up_c      = 1'b0;
    dn_c      = 1'b0;
    case (state)
      ST_INIT: begin
        // Parallel-load floor 0 so the floor register starts from a known value
        enb_c    = 1'b1;
        modo_c   = 1'b1;
        data_c   = 4'd0;
        state_nx = ST_IDLE;
      end
      ST_IDLE: begin
        ready_c = 1'b1;
        if (req_valid) begin
          if (floor_bad) begin
            err_nx = 1'b1;
          end else if (req_floor == Q) begin
            door_nx  = DOOR_LOAD;
            state_nx = ST_DOOR;
          end else if (req_floor > Q) begin
            target_nx = req_floor;
            step_nx   = STEP_LOAD;
            state_nx  = ST_MOVE_UP;
          end else begin
            target_nx = req_floor;
            step_nx   = STEP_LOAD;
            state_nx  = ST_MOVE_DOWN;
          end
        end
      end
      ST_MOVE_UP: begin
        up_c = 1'b1;
        // stop freezes the timer and suppresses the pulse
        if (!stop) begin
          if (step_tmr == '0) begin
            enb_c    = 1'b1;
            modo_c   = 1'b0;
            state_nx = ST_SETTLE_UP;
          end else begin
            step_nx = step_tmr - SW'(1);
          end
        end
      end
      ST_MOVE_DOWN: begin
        dn_c = 1'b1;
        // The counter cannot count down, so load Q-1 instead
        if (!stop) begin
          if (step_tmr == '0) begin
            enb_c    = 1'b1;
            modo_c   = 1'b1;
            data_c   = Q - 4'd1;
            state_nx = ST_SETTLE_DOWN;
          end else begin
            step_nx = step_tmr - SW'(1);
          end
        end
      end
      ST_SETTLE_UP: begin
        up_c = 1'b1;
        if (Q == target) begin
          door_nx  = DOOR_LOAD;
          state_nx = ST_DOOR;
        end else begin
          step_nx  = STEP_LOAD;
          state_nx = ST_MOVE_UP;
        end
      end
      ST_SETTLE_DOWN: begin
        dn_c = 1'b1;
        if (Q == target) begin
          door_nx  = DOOR_LOAD;
          state_nx = ST_DOOR;
        end else begin
          step_nx  = STEP_LOAD;
          state_nx = ST_MOVE_DOWN;
        end
      end
      ST_DOOR: begin
        door_c = 1'b1;
        if (door_tmr == '0) begin
          state_nx = ST_IDLE;
        end else begin
          door_nx = door_tmr - DW'(1);
        end
      end
      default: state_nx = ST_INIT;
    endcase
  end

  // While reset is asserted every output is held low, including the INIT load
  assign enb         = rst & enb_c;
  assign modo        = rst & modo_c;
  assign data        = rst ? data_c : 4'd0;
  assign req_ready   = rst & ready_c;
  assign req_err     = rst & err_q;
  assign door_open   = rst & door_c;
  assign moving_up   = rst & up_c;
  assign moving_down = rst & dn_c;

endmodule

// File: tb/tb_ctrl_ascensor.sv
// Directed bench for ctrl_ascensor with a behavioural 4-bit floor counter.
module tb_ctrl_ascensor;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid = 1'b0;
  logic [3:0] req_floor = 4'd0;
  logic       stop = 1'b0;
  logic       req_ready, req_err, enb, modo, door_open, moving_up, moving_down;
  logic [3:0] data;
  logic [3:0] q = 4'd5;

  int checks = 0;
  int failures = 0;

  ctrl_ascensor #(.NUM_FLOORS(8), .STEP_CYCLES(4), .DOOR_CYCLES(6)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_floor(req_floor),
    .req_ready(req_ready), .req_err(req_err), .stop(stop), .Q(q),
    .enb(enb), .modo(modo), .data(data), .door_open(door_open),
    .moving_up(moving_up), .moving_down(moving_down)
  );

  always #5 clk = ~clk;

  // Floor register: count up, or parallel load when modo=1
  always @(posedge clk) begin
    if (enb) q <= modo ? data : q + 4'd1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request in the current cycle; returns in cycle A+1
  task automatic send(input logic [3:0] f);
    req_valid = 1'b1;
    req_floor = f;
    #1;
    chk("acc_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    while (!req_ready && n < budget) begin
      tick();
      n++;
    end
    chk("ready_timeout", 32'(req_ready), 32'd1);
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({enb, modo, data, req_ready, req_err, door_open, moving_up, moving_down});
  endfunction

  initial begin
    // Reset held for 3 cycles: every output low
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rst_outs%0d", i), all_outs(), 32'd0);
    end
    rst = 1'b1;
    #1;
    chk("init_load", 32'({enb, modo, data}), 32'b110000);
    tick();
    chk("init_ready", 32'(req_ready), 32'd1);
    chk("init_q", 32'(q), 32'd0);

    // Up trip 0 -> 2: pulses at A+4, A+9; door A+11..A+16; ready A+17
    send(4'd2);
    for (int k = 1; k <= 17; k++) begin
      chk($sformatf("up_k%0d", k), 32'({enb, modo, door_open, moving_up, req_ready}),
          32'({(k == 4 || k == 9), 1'b0, (k >= 11 && k <= 16), (k <= 10), (k == 17)}));
      if (k < 17) tick();
    end
    chk("up_q", 32'(q), 32'd2);

    // One more floor up to reach 3
    send(4'd3);
    wait_ready(40);
    chk("to3_q", 32'(q), 32'd3);

    // Down trip 3 -> 1: loads of 2 then 1
    send(4'd1);
    for (int k = 1; k <= 17; k++) begin
      logic       pe;
      logic [3:0] de;
      pe = (k == 4 || k == 9);
      de = (k == 4) ? 4'd2 : (k == 9) ? 4'd1 : 4'd0;
      chk($sformatf("dn_k%0d", k), 32'({enb, modo, data, moving_down, door_open}),
          32'({pe, pe, de, (k <= 10), (k >= 11 && k <= 16)}));
      if (k == 11) chk("dn_q", 32'(q), 32'd1);
      if (k < 17) tick();
    end
    chk("dn_ready", 32'(req_ready), 32'd1);

    // Same floor: door opens next cycle, no step pulse
    send(4'd1);
    for (int k = 1; k <= 7; k++) begin
      chk($sformatf("same_k%0d", k), 32'({door_open, enb, req_ready}),
          32'({(k <= 6), 1'b0, (k == 7)}));
      if (k < 7) tick();
    end

    // Invalid floor (>= 8): one-cycle error pulse, remain idle
    send(4'd9);
    chk("err_pulse", 32'({req_err, req_ready, door_open, moving_up}), 32'b1100);
    tick();
    chk("err_clear", 32'({req_err, req_ready}), 32'b01);
    chk("err_q", 32'(q), 32'd1);

    // Stop over the would-be pulse cycle: pulse moves from A+4 to A+9
    send(4'd3);
    for (int k = 1; k <= 9; k++) begin
      if (k == 4) stop = 1'b1;
      if (k == 9) stop = 1'b0;
      #1;
      chk($sformatf("stop_k%0d", k), 32'({enb, moving_up}), 32'({(k == 9), 1'b1}));
      if (k < 9) tick();
    end
    wait_ready(60);
    chk("stop_q", 32'(q), 32'd3);

    // Ignored request mid-trip, then reset mid-trip
    send(4'd6);
    for (int k = 1; k <= 6; k++) begin
      if (k == 2) begin
        req_valid = 1'b1;
        req_floor = 4'd7;
        #1;
        chk("busy_ready", 32'({req_ready, moving_up}), 32'b01);
      end
      if (k == 3) req_valid = 1'b0;
      if (k == 4) chk("mid_pulse", 32'({enb, modo}), 32'b10);
      if (k == 5) chk("mid_q", 32'(q), 32'd4);
      if (k < 6) tick();
    end
    rst = 1'b0;
    #1;
    chk("mid_rst_outs", all_outs(), 32'd0);
    tick();
    chk("mid_rst_outs2", all_outs(), 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_init_load", 32'({enb, modo, data, req_ready}), 32'b1100000);
    tick();
    chk("mid_ready", 32'(req_ready), 32'd1);
    chk("mid_q0", 32'(q), 32'd0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("no_resume%0d", k), 32'({enb, moving_up, moving_down, door_open, req_ready}), 32'b00001);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ctrl_ascensor.md
Name: ctrl_ascensor

Overview:
Elevator motion controller that sits directly upstream of the 4-bit up-counter used as the floor register. It accepts floor requests over a valid/ready handshake. It drives the counter's enb/modo/data inputs to step the cabin one floor at a time and reads the counter output Q back as the current floor. When the cabin reaches the target floor, it runs a door-open interval. The counter only counts up, so a downward step is done by parallel-loading Q-1 (modo=1).

Parameters:
NUM_FLOORS, 16, number of valid floors (0..NUM_FLOORS-1), 2..16
STEP_CYCLES, 4, clock cycles per floor step before the counter is pulsed, >=1
DOOR_CYCLES, 6, clock cycles door_open is held high, >=1

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-low (rst=0 resets on next rising edge)
req_valid  input  1  floor request present
req_floor  input  4  requested floor
req_ready  output  1  controller can accept a request (IDLE only)
req_err  output  1  one-cycle pulse: accepted request had req_floor >= NUM_FLOORS
stop  input  1  emergency hold; freezes motion while high
Q  input  4  current floor, from counter
enb  output  1  counter enable, one-cycle pulses
modo  output  1  counter mode: 1 = parallel load data, 0 = count up
data  output  4  counter parallel-load value
door_open  output  1  door open indicator
moving_up  output  1  high in MOVE_UP and its SETTLE
moving_down  output  1  high in MOVE_DOWN and its SETTLE

Behaviour:
- Reset (rst=0 at an edge): state=INIT, target=0, timers=0. All outputs 0: enb, modo, data, req_ready, req_err, door_open, moving_up, moving_down.
- INIT (1 cycle): enb=1, modo=1, data=0, which loads floor 0 into the counter. Next state is IDLE.
- IDLE: req_ready=1, enb=0. A handshake occurs when req_valid && req_ready.
  - req_floor >= NUM_FLOORS: req_err=1 for the next cycle; stay in IDLE.
  - req_floor == Q: go to DOOR.
  - req_floor > Q: latch target; go to MOVE_UP.
  - req_floor < Q: latch target; go to MOVE_DOWN.
- MOVE_x: on entry, step timer = STEP_CYCLES-1; it decrements each cycle.
  - In the cycle the timer is 0, issue the step pulse, then go to SETTLE_x.
    - UP: enb=1, modo=0.
    - DOWN: enb=1, modo=1, data=Q-1.
  - enb is 0 in all other MOVE cycles.
- SETTLE_x (1 cycle): Q already reflects the step.
  - Q==target: go to DOOR.
  - Otherwise: reload the timer and return to MOVE_x.
  - Each floor therefore costs STEP_CYCLES+1 cycles.
- DOOR: door_open=1 for exactly DOOR_CYCLES cycles, then IDLE. moving_up and moving_down are 0.
- stop=1 in MOVE_x:
  - The timer holds its value and enb is forced to 0.
  - Counting resumes from the held value when stop falls.
  - stop has no effect in IDLE, SETTLE or DOOR.
- Requests outside IDLE: req_ready=0; req_valid is ignored; nothing is queued.
- Boundary cases:
  - MOVE_DOWN is never entered with Q=0, and MOVE_UP never with Q=15, because target strictly differs.
  - data wraps modulo 16 only if Q is externally corrupted; no check is performed.
- Reset mid-operation: any state, with or without a step pulse pending, returns to INIT. The latched target is discarded.
- enb is never high for two consecutive cycles.

Test Plan:
- Reset/INIT: hold rst=0 for 3 cycles, release. Required: all outputs 0 during reset. The first cycle after release shows enb=1, modo=1, data=0. The next cycle shows req_ready=1.
- Up trip: Q=0, request floor 2 accepted at cycle A (STEP=4, DOOR=6). Required:
  - enb=1, modo=0 at A+4 and A+9.
  - door_open=1 at A+11..A+16.
  - req_ready=1 at A+17.
- Down trip: from Q=3, request floor 1. Required:
  - two load pulses with modo=1, data=2 then data=1;
  - moving_down=1 throughout;
  - door opens after Q=1.
- Same floor and invalid request:
  - Request req_floor==Q: door_open rises the next cycle, with no enb pulse.
  - NUM_FLOORS=8, req_floor=9: req_err pulses one cycle; state stays IDLE.
- Stop hold: assert stop for 5 cycles mid-MOVE_UP. Required: no enb pulse during the hold, and the step pulse is delayed by exactly 5 cycles.
- Reset mid-trip and ignored request:
  - During MOVE_UP, req_valid=1 with a new floor: req_ready=0 and the request is ignored.
  - rst=0 then released: INIT load of floor 0 occurs and the old target is not resumed.
